// File: rtl/sonic_pcs_pkg.sv
// Shared PCS definitions for the SoNIC 10G transmit and receive channels:
// sync headers, datapath widths and the 66-bit block layout.
package sonic_pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam int BLOCK_W   = 66;
    localparam int XCVR_W    = 40;
    localparam int PAYLOAD_W = 64;
    localparam int SCR_W     = 58;

    // Worst case merge: 39 pending bits plus one full block.
    localparam int BUF_W = 105;
    localparam int CNT_W = 7;

    localparam logic [7:0] IDLE_BLOCK_TYPE = 8'h1E;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [1:0]           header;
    } pcs_block_t;

endpackage

// File: rtl/sonic_scrambler_58.sv
// Self-synchronous x^58+x^39+1 payload scrambler, LSB first. It is the
// counterpart of the receive-side descrambler.
module sonic_scrambler_58
    import sonic_pcs_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [PAYLOAD_W-1:0] data_in,
    output logic [PAYLOAD_W-1:0] data_out
);

    logic [SCR_W-1:0] state_reg;
    logic [SCR_W-1:0] state_next;

    // Serial history: [57:0] is the prior state (oldest at bit 0), then the
    // freshly scrambled bits, so o_i taps history bits i+19 and i.
    always_comb begin
        logic [SCR_W+PAYLOAD_W-1:0] hist;
        hist = {{PAYLOAD_W{1'b0}}, state_reg};
        for (int i = 0; i < PAYLOAD_W; i++) begin
            hist[SCR_W+i] = data_in[i] ^ hist[i+SCR_W-39] ^ hist[i];
        end
        data_out   = hist[SCR_W+PAYLOAD_W-1:SCR_W];
        state_next = hist[SCR_W+PAYLOAD_W-1:PAYLOAD_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= '1;
        end else if (clear) begin
            state_reg <= '1;
        end else if (enable) begin
            state_reg <= state_next;
        end
    end

endmodule

// File: rtl/sonic_tx_chan_66.sv
// SoNIC 10G transmit channel: scrambles 66-bit blocks and packs them into the
// continuous 40-bit transceiver word stream, inserting idles on underflow.
module sonic_tx_chan_66
    import sonic_pcs_pkg::*;
#(
    parameter logic [63:0] IDLE_PAYLOAD = {56'h0, IDLE_BLOCK_TYPE}
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               xcvr_tx_ready,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [XCVR_W-1:0]  data_out,
    output logic [15:0]        idle_count
);

    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [BUF_W-1:0]     buf_reg, buf_next;
    logic [XCVR_W-1:0]    data_out_reg, data_out_next;
    logic [15:0]          idle_count_reg, idle_count_next;

    logic                 load;
    pcs_block_t           blk_sel;
    logic [PAYLOAD_W-1:0] scr_payload;
    logic [BLOCK_W-1:0]   blk_scr;
    logic [BUF_W-1:0]     blk_ext;
    logic [BUF_W-1:0]     merged;

    assign load     = (cnt_reg < 7'd40);
    assign in_ready = reset_n & xcvr_tx_ready & load;

    // Underflow on a load cycle always substitutes a whole idle block.
    assign blk_sel = in_valid ? pcs_block_t'(data_in)
                              : pcs_block_t'({IDLE_PAYLOAD, SYNC_CTRL});

    sonic_scrambler_58 u_scrambler (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (~xcvr_tx_ready),
        .enable   (xcvr_tx_ready & load),
        .data_in  (blk_sel.payload),
        .data_out (scr_payload)
    );

    assign blk_scr = {scr_payload, blk_sel.header};
    assign blk_ext = {{(BUF_W-BLOCK_W){1'b0}}, blk_scr};

    always_comb begin
        merged          = buf_reg;
        cnt_next        = cnt_reg - 7'd40;
        idle_count_next = idle_count_reg;
        if (load) begin
            merged   = buf_reg | (blk_ext << cnt_reg);
            cnt_next = cnt_reg + 7'd26;
            if (!in_valid && idle_count_reg != 16'hFFFF) begin
                idle_count_next = idle_count_reg + 16'd1;
            end
        end
        data_out_next = merged[XCVR_W-1:0];
        buf_next      = merged >> XCVR_W;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg        <= '0;
            buf_reg        <= '0;
            data_out_reg   <= '0;
            idle_count_reg <= '0;
        end else if (!xcvr_tx_ready) begin
            cnt_reg      <= '0;
            buf_reg      <= '0;
            data_out_reg <= '0;
        end else begin
            cnt_reg        <= cnt_next;
            buf_reg        <= buf_next;
            data_out_reg   <= data_out_next;
            idle_count_reg <= idle_count_next;
        end
    end

    assign data_out   = data_out_reg;
    assign idle_count = idle_count_reg;

endmodule

// File: tb/tb_sonic_tx_chan_66.sv
// Directed and loopback bench for the transmit channel, with a reference
// receive path (40->66 gearbox, block lock, serial descrambler).
module tb_sonic_tx_chan_66;
    import sonic_pcs_pkg::*;

    localparam logic [63:0] IDLE_PL  = 64'h0000_0000_0000_001E;
    localparam int          N_BLOCKS = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        xcvr_tx_ready;
    logic [65:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] data_out;
    logic [15:0] idle_count;

    int n_checks = 0;
    int n_pass   = 0;

    sonic_tx_chan_66 dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .xcvr_tx_ready (xcvr_tx_ready),
        .data_in       (data_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_out      (data_out),
        .idle_count    (idle_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    logic [65:0] sent [N_BLOCKS];
    bit          rx_bits [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rdy_pat;
        logic [15:0] idle0;
        int          m_cnt, hs0, hs1, bad_rdy, bad_zero, idx, chunks, cycles;
        int          lock_off, m, n_idle, bad, nb;
        logic [57:0] ds;
        logic [63:0] pl;
        logic [1:0]  h;
        logic        o, acc;

        reset_n       = 1'b0;
        xcvr_tx_ready = 1'b1;
        in_valid      = 1'b0;
        data_in       = '0;

        // Reset state and idle insertion from cnt=0.
        tick();
        tick();
        check_eq("rst_data_out", 66'(data_out), 66'h0);
        check_eq("rst_in_ready", 66'(in_ready), 66'h0);
        check_eq("rst_idle_count", 66'(idle_count), 66'h0);
        reset_n = 1'b1;
        #1;
        rdy_pat = 8'h5B;
        for (int c = 0; c < 8; c++) begin
            check_eq($sformatf("idle_rdy_c%0d", c), 66'(in_ready), 66'(rdy_pat[c]));
            tick();
            if (c == 0) check_eq("idle_first_word", 66'(data_out), 66'h79);
        end
        check_eq("idle_count_8cyc", 66'(idle_count), 66'd5);
        $display("phase reset/idle: idle_count=%0d", idle_count);

        // Scrambler vector: zero data block from reset state.
        do_reset();
        data_in  = {64'h0, SYNC_DATA};
        in_valid = 1'b1;
        #1;
        check_eq("scr_in_ready", 66'(in_ready), 66'h1);
        tick();
        in_valid = 1'b0;
        check_eq("scr_first_word", 66'(data_out), 66'h2);
        $display("phase scrambler: data_out=%010h", data_out);

        // Continuous valid: 20 handshakes per 33 cycles, no idles.
        do_reset();
        in_valid = 1'b1;
        m_cnt = 0; hs0 = 0; hs1 = 0; bad_rdy = 0;
        for (int c = 0; c < 66; c++) begin
            data_in = {$urandom, $urandom, SYNC_DATA};
            #1;
            if (in_ready !== (m_cnt < 40)) bad_rdy++;
            if (in_ready && in_valid) begin
                if (c < 33) hs0++; else hs1++;
            end
            m_cnt = (m_cnt < 40) ? m_cnt + 26 : m_cnt - 40;
            tick();
        end
        check_eq("cont_hs_first33", 66'(hs0), 66'd20);
        check_eq("cont_hs_second33", 66'(hs1), 66'd20);
        check_eq("cont_rdy_pattern_bad", 66'(bad_rdy), 66'd0);
        check_eq("cont_idle_count", 66'(idle_count), 66'd0);
        $display("phase continuous: handshakes=%0d/%0d", hs0, hs1);

        // Transceiver not ready for 5 cycles mid-stream.
        for (int c = 0; c < 3; c++) tick();
        idle0 = idle_count;
        xcvr_tx_ready = 1'b0;
        bad_zero = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (in_ready !== 1'b0) bad_zero++;
            tick();
            if (data_out !== 40'h0) bad_zero++;
        end
        in_valid = 1'b0;
        check_eq("xrdy_low_outputs_bad", 66'(bad_zero), 66'd0);
        check_eq("xrdy_idle_held", 66'(idle_count), 66'(idle0));
        xcvr_tx_ready = 1'b1;
        data_in  = {64'h0, SYNC_DATA};
        in_valid = 1'b1;
        #1;
        check_eq("xrdy_rise_in_ready", 66'(in_ready), 66'h1);
        tick();
        in_valid = 1'b0;
        check_eq("xrdy_rise_first_word", 66'(data_out), 66'h2);
        $display("phase xcvr_tx_ready drop: data_out=%010h", data_out);

        // Loopback through the reference receive path.
        for (int i = 0; i < N_BLOCKS; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                sent[i] = {$urandom, $urandom, SYNC_DATA};
            end else begin
                pl = {$urandom, $urandom};
                if (pl == IDLE_PL) pl[8] = 1'b1;
                sent[i] = {pl, SYNC_CTRL};
            end
        end
        xcvr_tx_ready = 1'b0;
        tick();
        xcvr_tx_ready = 1'b1;
        #1;
        idle0 = idle_count;
        idx = 0; chunks = 0; cycles = 0;
        while (idx < N_BLOCKS && chunks < 150) begin
            for (int c = 0; c < 33; c++) begin
                if (!in_valid) in_valid = (idx < N_BLOCKS) && ($urandom_range(0, 3) != 0);
                if (in_valid) data_in = sent[idx];
                #1;
                acc = in_valid & in_ready;
                tick();
                cycles++;
                if (acc) begin
                    idx++;
                    in_valid = 1'b0;
                end
                for (int b = 0; b < 40; b++) rx_bits.push_back(data_out[b]);
            end
            chunks++;
        end
        in_valid = 1'b0;
        check_eq("loop_all_sent", 66'(idx), 66'(N_BLOCKS));

        lock_off = -1;
        for (int off = 0; off < 66 && lock_off < 0; off++) begin
            bit ok;
            ok = 1'b1;
            for (int b = 0; b < 64; b++) begin
                int p;
                p = off + 66 * b;
                if (p + 1 >= rx_bits.size() || rx_bits[p] == rx_bits[p+1]) ok = 1'b0;
            end
            if (ok) lock_off = off;
        end
        check_eq("loop_lock_offset", 66'(lock_off), 66'd0);
        if (lock_off < 0) lock_off = 0;

        ds = '1; m = 0; n_idle = 0; bad = 0; nb = 0;
        for (int p = lock_off; p + 66 <= rx_bits.size(); p += 66) begin
            h = {rx_bits[p+1], rx_bits[p]};
            for (int i = 0; i < 64; i++) begin
                o     = rx_bits[p+2+i];
                pl[i] = o ^ ds[38] ^ ds[57];
                ds    = {ds[56:0], o};
            end
            nb++;
            if (m < N_BLOCKS && {pl, h} == sent[m]) m++;
            else if ({pl, h} == {IDLE_PL, SYNC_CTRL}) n_idle++;
            else bad++;
        end
        check_eq("loop_block_count", 66'(nb), 66'(cycles * 20 / 33));
        check_eq("loop_in_order", 66'(m), 66'(N_BLOCKS));
        check_eq("loop_bad_blocks", 66'(bad), 66'd0);
        check_eq("loop_idle_delta", 66'(n_idle), 66'(idle_count - idle0));
        $display("phase loopback: blocks=%0d sent=%0d idles=%0d bad=%0d", nb, m, n_idle, bad);

        // Asynchronous reset between clock edges.
        for (int c = 0; c < 4; c++) tick();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("arst_data_out", 66'(data_out), 66'h0);
        check_eq("arst_in_ready", 66'(in_ready), 66'h0);
        check_eq("arst_idle_count", 66'(idle_count), 66'h0);
        tick();
        #1;
        reset_n = 1'b1;
        #1;
        check_eq("arst_release_in_ready", 66'(in_ready), 66'h1);
        tick();
        check_eq("arst_first_word", 66'(data_out), 66'h79);
        $display("phase async reset: data_out=%010h idle_count=%0d", data_out, idle_count);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
